// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    // Width of the wait counter; bounds the legal timeout range to 1..255.
    localparam int unsigned TIMER_W = 8;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        StIdle,
        StServeI,
        StServeD
    } stateT;

    typedef enum logic {
        OwnerI,
        OwnerD
    } ownerT;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for an outstanding memory access, with compare against a limit.
module mem_arb_timer
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    // Count wait cycles; saturate so a stuck enable can never wrap to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    // Fetch requester (read-only)
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_done,
    output logic        i_err,
    output logic [31:0] i_rdata,
    // Data requester
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] d_rdata,
    // Shared memory port
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);

    localparam logic [TIMER_W-1:0] Limit = TIMER_W'(TIMEOUT_CYCLES);

    stateT state;
    ownerT lastOwner;
    logic  iElig;
    logic  dElig;
    logic  grantI;
    logic  grantD;
    logic  timerClear;
    logic  timerEn;
    logic  expired;

    // Eligibility and round-robin pick; a port in its done cycle is not eligible.
    always_comb begin
        iElig      = i_req && !i_done;
        dElig      = d_req && !d_done;
        grantD     = dElig && (!iElig || (lastOwner == OwnerI));
        grantI     = iElig && !grantD;
        timerClear = (state == StIdle);
        timerEn    = (state != StIdle) && !m_ready;
    end

    mem_arb_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timerClear),
        .en      (timerEn),
        .limit   (Limit),
        .expired (expired)
    );

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            lastOwner <= OwnerI;
            i_gnt     <= 1'b0;
            i_done    <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
        end else begin
            // Grant, done and err are single-cycle pulses.
            i_gnt  <= 1'b0;
            i_done <= 1'b0;
            i_err  <= 1'b0;
            d_gnt  <= 1'b0;
            d_done <= 1'b0;
            d_err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (grantD) begin
                        d_gnt     <= 1'b1;
                        m_req     <= 1'b1;
                        m_we      <= d_we;
                        m_addr    <= d_addr;
                        m_wdata   <= d_wdata;
                        lastOwner <= OwnerD;
                        state     <= StServeD;
                    end else if (grantI) begin
                        i_gnt     <= 1'b1;
                        m_req     <= 1'b1;
                        m_we      <= 1'b0;
                        m_addr    <= i_addr;
                        m_wdata   <= '0;
                        lastOwner <= OwnerI;
                        state     <= StServeI;
                    end
                end
                StServeI: begin
                    // A ready in the expiry cycle still wins over the abort.
                    if (m_ready) begin
                        m_req   <= 1'b0;
                        i_done  <= 1'b1;
                        i_rdata <= m_rdata;
                        state   <= StIdle;
                    end else if (expired) begin
                        m_req   <= 1'b0;
                        i_done  <= 1'b1;
                        i_err   <= 1'b1;
                        i_rdata <= '0;
                        state   <= StIdle;
                    end
                end
                StServeD: begin
                    if (m_ready) begin
                        m_req  <= 1'b0;
                        d_done <= 1'b1;
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                        state <= StIdle;
                    end else if (expired) begin
                        m_req   <= 1'b0;
                        d_done  <= 1'b1;
                        d_err   <= 1'b1;
                        d_rdata <= '0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_gnt, i_done, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_done, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int nTests = 0;
    int nFail  = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_done  (i_done),
        .i_err   (i_err),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_done  (d_done),
        .d_err   (d_err),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    // Advance one cycle; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_ready = 1'b0;
        m_rdata = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        idleInputs();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Dirty some state first so reset has something to clear.
        doReset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234_5678;
        step();
        step();
        doReset();
        nTests++;
        if ({i_gnt, i_done, i_err, d_gnt, d_done, d_err, m_req, m_we} !== 8'h00) begin
            nFail++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {i_gnt, i_done, i_err, d_gnt, d_done, d_err, m_req, m_we});
        end
        nTests++;
        if ({i_rdata, d_rdata, m_addr, m_wdata} !== 128'h0) begin
            nFail++;
            $display("FAIL reset_data: got %h %h %h %h want all zero",
                     i_rdata, d_rdata, m_addr, m_wdata);
        end
    endtask

    task automatic test_fetch();
        doReset();
        m_ready = 1'b1; m_rdata = 32'h2010_0005;
        i_req = 1'b1; i_addr = 32'h0000_0040;
        step();
        nTests++;
        if (i_gnt !== 1'b1 || m_req !== 1'b1 || m_addr !== 32'h40 || m_we !== 1'b0
            || i_done !== 1'b0) begin
            nFail++;
            $display("FAIL fetch_grant: gnt=%b mreq=%b addr=%h we=%b done=%b want 1 1 40 0 0",
                     i_gnt, m_req, m_addr, m_we, i_done);
        end
        step();
        nTests++;
        if (i_done !== 1'b1 || i_err !== 1'b0 || i_rdata !== 32'h2010_0005 || m_req !== 1'b0)
        begin
            nFail++;
            $display("FAIL fetch_done: done=%b err=%b rdata=%h mreq=%b want 1 0 20100005 0",
                     i_done, i_err, i_rdata, m_req);
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_priority();
        doReset();
        m_ready = 1'b1; m_rdata = 32'h0000_1111;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        step();
        nTests++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || m_we !== 1'b1 || m_addr !== 32'h100
            || m_wdata !== 32'hDEAD_BEEF) begin
            nFail++;
            $display("FAIL prio_data_first: dg=%b ig=%b we=%b addr=%h wd=%h want 1 0 1 100 deadbeef",
                     d_gnt, i_gnt, m_we, m_addr, m_wdata);
        end
        step();
        nTests++;
        if (d_done !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'h0) begin
            nFail++;
            $display("FAIL prio_data_done: done=%b err=%b rdata=%h want 1 0 0 (write holds)",
                     d_done, d_err, d_rdata);
        end
        d_req = 1'b0;
        step();
        nTests++;
        if (i_gnt !== 1'b1 || m_we !== 1'b0 || m_addr !== 32'h40) begin
            nFail++;
            $display("FAIL prio_fetch_next: ig=%b we=%b addr=%h want 1 0 40", i_gnt, m_we, m_addr);
        end
        step();
        nTests++;
        if (i_done !== 1'b1 || i_rdata !== 32'h1111) begin
            nFail++;
            $display("FAIL prio_fetch_done: done=%b rdata=%h want 1 1111", i_done, i_rdata);
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_alternate();
        bit seq[$];
        doReset();
        m_ready = 1'b1; m_rdata = 32'h7;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int c = 0; c < 40 && seq.size() < 6; c++) begin
            step();
            if (i_gnt) seq.push_back(1'b0);
            if (d_gnt) seq.push_back(1'b1);
            // Drop req in the done cycle, raise it again the cycle after.
            i_req = !i_done;
            d_req = !d_done;
        end
        for (int n = 0; n < 6; n++) begin
            nTests++;
            if (n >= seq.size()) begin
                nFail++;
                $display("FAIL alt_grant %0d: got none want %s", n, (n % 2 == 0) ? "D" : "I");
            end else if (seq[n] != ((n % 2) == 0)) begin
                nFail++;
                $display("FAIL alt_grant %0d: got %s want %s", n, seq[n] ? "D" : "I",
                         (n % 2 == 0) ? "D" : "I");
            end
        end
        idleInputs();
        step();
        step();
    endtask

    task automatic test_timeout();
        int gntAt;
        int doneAt;
        doReset();
        // Preload d_rdata so the abort visibly clears it.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
        step();
        step();
        nTests++;
        if (d_done !== 1'b1 || d_rdata !== 32'hCAFE_F00D) begin
            nFail++;
            $display("FAIL to_preload: done=%b rdata=%h want 1 cafef00d", d_done, d_rdata);
        end
        d_req = 1'b0; m_ready = 1'b0;
        step();
        d_req = 1'b1; d_addr = 32'h300;
        gntAt = -1;
        doneAt = -1;
        for (int c = 1; c <= 20 && doneAt < 0; c++) begin
            step();
            if (d_gnt) gntAt = c;
            if (d_done) begin
                doneAt = c;
                nTests++;
                if (d_err !== 1'b1 || d_rdata !== 32'h0 || m_req !== 1'b0) begin
                    nFail++;
                    $display("FAIL to_abort: err=%b rdata=%h mreq=%b want 1 0 0",
                             d_err, d_rdata, m_req);
                end
                d_req = 1'b0;
            end
        end
        nTests++;
        if (gntAt < 0 || doneAt < 0 || (doneAt - gntAt) != int'(TO + 1)) begin
            nFail++;
            $display("FAIL to_latency: gnt at %0d done at %0d want done %0d cycles after gnt",
                     gntAt, doneAt, TO + 1);
        end
        idleInputs();
        step();
    endtask

    task automatic test_reset_mid();
        doReset();
        m_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h9;
        step();
        nTests++;
        if (d_gnt !== 1'b1) begin
            nFail++;
            $display("FAIL rmid_grant: dg=%b want 1", d_gnt);
        end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        nTests++;
        if (m_req !== 1'b0 || d_done !== 1'b0 || d_err !== 1'b0) begin
            nFail++;
            $display("FAIL rmid_abandon: mreq=%b done=%b err=%b want 0 0 0", m_req, d_done, d_err);
        end
        d_req = 1'b0;
        i_req = 1'b1; i_addr = 32'h80; m_ready = 1'b1; m_rdata = 32'h55;
        step();
        nTests++;
        if (i_gnt !== 1'b1 || m_addr !== 32'h80 || m_req !== 1'b1) begin
            nFail++;
            $display("FAIL rmid_fresh_grant: ig=%b addr=%h mreq=%b want 1 80 1", i_gnt, m_addr, m_req);
        end
        step();
        nTests++;
        if (i_done !== 1'b1 || i_err !== 1'b0 || i_rdata !== 32'h55) begin
            nFail++;
            $display("FAIL rmid_fresh_done: done=%b err=%b rdata=%h want 1 0 55",
                     i_done, i_err, i_rdata);
        end
        idleInputs();
        step();
    endtask

    // Random traffic. Each transaction draws k = cycles of m_ready low after
    // the grant; done is expected at grant + 1 + min(k, TO), err iff k > TO.
    task automatic test_random();
        bit busy, ownD, lastD, errExp, txWe;
        int gntCycle, doneCycle, k;
        logic [31:0] txAddr, txWdata, readyData, expIR, expDR;
        bit pIReq, pDReq, pDWe, pIDone, pDDone;
        logic [31:0] pIAddr, pDAddr, pDWdata;
        bit eIG, eDG, eID, eDD, eIE, eDE, eligI, eligD, rdy;
        doReset();
        busy = 0; ownD = 0; lastD = 0; errExp = 0; txWe = 0;
        gntCycle = 0; doneCycle = 0; k = 0;
        txAddr = '0; txWdata = '0; readyData = '0; expIR = '0; expDR = '0;
        pIReq = 0; pDReq = 0; pDWe = 0; pIDone = 0; pDDone = 0;
        pIAddr = '0; pDAddr = '0; pDWdata = '0;
        for (int t = 0; t < 1500; t++) begin
            {eIG, eDG, eID, eDD, eIE, eDE} = '0;
            if (busy && t == doneCycle) begin
                busy = 0;
                if (ownD) begin
                    eDD = 1; eDE = errExp;
                    if (errExp) expDR = '0;
                    else if (!txWe) expDR = readyData;
                end else begin
                    eID = 1; eIE = errExp;
                    expIR = errExp ? 32'h0 : readyData;
                end
            end else if (!busy) begin
                eligI = pIReq && !pIDone;
                eligD = pDReq && !pDDone;
                if (eligI || eligD) begin
                    ownD = eligD && (!eligI || !lastD);
                    lastD = ownD;
                    busy = 1;
                    gntCycle = t;
                    k = $urandom_range(0, TO + 2);
                    doneCycle = t + 1 + ((k < int'(TO)) ? k : int'(TO));
                    errExp = (k > int'(TO));
                    if (ownD) begin
                        eDG = 1; txAddr = pDAddr; txWe = pDWe; txWdata = pDWdata;
                    end else begin
                        eIG = 1; txAddr = pIAddr; txWe = 0; txWdata = '0;
                    end
                end
            end

            nTests++;
            if ({i_gnt, d_gnt, i_done, d_done, i_err, d_err} !== {eIG, eDG, eID, eDD, eIE, eDE})
            begin
                nFail++;
                $display("FAIL rand_pulses cyc %0d: got %b want %b (ig dg id dd ie de)", t,
                         {i_gnt, d_gnt, i_done, d_done, i_err, d_err},
                         {eIG, eDG, eID, eDD, eIE, eDE});
            end
            nTests++;
            if (m_req !== busy) begin
                nFail++;
                $display("FAIL rand_mreq cyc %0d: got %b want %b", t, m_req, busy);
            end
            if (busy) begin
                nTests++;
                if (m_addr !== txAddr || m_we !== txWe || (ownD && m_wdata !== txWdata)) begin
                    nFail++;
                    $display("FAIL rand_mbus cyc %0d: got %h %b %h want %h %b %h", t,
                             m_addr, m_we, m_wdata, txAddr, txWe, txWdata);
                end
            end
            nTests++;
            if (i_rdata !== expIR || d_rdata !== expDR) begin
                nFail++;
                $display("FAIL rand_rdata cyc %0d: got %h %h want %h %h", t,
                         i_rdata, d_rdata, expIR, expDR);
            end

            // Requesters drop req in their done cycle and hold it while pending.
            if (eID) i_req = 1'b0;
            else if (!i_req) i_req = 1'($urandom_range(0, 1));
            if (eDD) d_req = 1'b0;
            else if (!d_req) d_req = 1'($urandom_range(0, 1));
            i_addr  = $urandom;
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_we    = 1'($urandom_range(0, 1));
            m_rdata = $urandom;
            rdy = 0;
            if (busy) rdy = ((t - gntCycle) == k) && (k <= int'(TO));
            else rdy = 1'($urandom_range(0, 1));
            m_ready = rdy;
            if (busy && rdy) readyData = m_rdata;

            pIReq = i_req; pIAddr = i_addr; pDReq = d_req; pDWe = d_we;
            pDAddr = d_addr; pDWdata = d_wdata; pIDone = eID; pDDone = eDD;
            step();
        end
        idleInputs();
        step();
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        test_reset();
        test_fetch();
        test_priority();
        test_alternate();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
